// File: rtl/serial_mag_compare_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_mag_compare_ctrl_pkg
// Description : Shared state encoding and default operand width for the
//               serial magnitude comparator.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_mag_compare_ctrl_pkg;

    localparam int c_DEFAULT_WIDTH = 8;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE = 2'd0;
    localparam state_t c_ST_CMP  = 2'd1;
    localparam state_t c_ST_DONE = 2'd2;

endpackage
`default_nettype wire

// File: rtl/serial_mag_compare_ctrl_cmp1.sv
`default_nettype none
// ============================================================================
// Module      : mag_comparator_1bit
// Description : Single-bit magnitude comparator cell (x vs y).
// Revision    : 1.0 - initial release
// ============================================================================
module mag_comparator_1bit (
    input  logic x,
    input  logic y,
    output logic g,
    output logic e,
    output logic l
);

    assign g = x & ~y;
    assign e = ~(x ^ y);
    assign l = ~x & y;

endmodule
`default_nettype wire

// File: rtl/serial_mag_compare_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_mag_compare_ctrl
// Description : Bit-serial MSB-first unsigned magnitude comparator with
//               early termination on the first differing bit pair.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_mag_compare_ctrl
    import serial_mag_compare_ctrl_pkg::*;
#(
    parameter int WIDTH = c_DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int                 c_IDX_W   = $clog2(WIDTH);
    localparam logic [c_IDX_W-1:0] c_IDX_MAX = c_IDX_W'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_a_sh;
    logic [WIDTH-1:0]   r_b_sh;
    logic [c_IDX_W-1:0] r_idx;
    logic               r_gt;
    logic               r_eq;
    logic               r_lt;
    logic               w_bit_g;
    logic               w_bit_e;
    logic               w_bit_l;

    // The shift registers present the current bit pair on their MSBs.
    mag_comparator_1bit u_cmp1 (
        .x (r_a_sh[WIDTH-1]),
        .y (r_b_sh[WIDTH-1]),
        .g (w_bit_g),
        .e (w_bit_e),
        .l (w_bit_l)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (start) begin
                    w_state_nxt = c_ST_CMP;
                end
            end
            c_ST_CMP: begin
                if (!w_bit_e || (r_idx == '0)) begin
                    w_state_nxt = c_ST_DONE;
                end
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a_sh <= '0;
            r_b_sh <= '0;
            r_idx  <= '0;
            r_gt   <= 1'b0;
            r_eq   <= 1'b0;
            r_lt   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (start) begin
                        r_a_sh <= a;
                        r_b_sh <= b;
                        r_idx  <= c_IDX_MAX;
                        r_gt   <= 1'b0;
                        r_eq   <= 1'b0;
                        r_lt   <= 1'b0;
                    end
                end
                c_ST_CMP: begin
                    r_a_sh <= {r_a_sh[WIDTH-2:0], 1'b0};
                    r_b_sh <= {r_b_sh[WIDTH-2:0], 1'b0};
                    if (!w_bit_e) begin
                        r_gt <= w_bit_g;
                        r_lt <= w_bit_l;
                        r_eq <= 1'b0;
                    end else if (r_idx == '0) begin
                        r_gt <= 1'b0;
                        r_lt <= 1'b0;
                        r_eq <= 1'b1;
                    end else begin
                        r_idx <= r_idx - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy = (r_state == c_ST_CMP) || (r_state == c_ST_DONE);
    assign done = (r_state == c_ST_DONE);
    assign gt   = r_gt;
    assign eq   = r_eq;
    assign lt   = r_lt;

endmodule
`default_nettype wire

// File: tb/tb_serial_mag_compare_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_mag_compare_ctrl
// Description : Self-checking bench for serial_mag_compare_ctrl (WIDTH=8).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_mag_compare_ctrl;

    localparam int c_W = 8;

    logic           clk;
    logic           rst;
    logic           start;
    logic [c_W-1:0] a;
    logic [c_W-1:0] b;
    logic           busy;
    logic           done;
    logic           gt;
    logic           eq;
    logic           lt;

    int n_checks;
    int n_fail;

    serial_mag_compare_ctrl #(.WIDTH(c_W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .gt    (gt),
        .eq    (eq),
        .lt    (lt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: result flags {gt,eq,lt} from plain unsigned arithmetic.
    function automatic logic [2:0] ref_flags(input logic [c_W-1:0] x, input logic [c_W-1:0] y);
        return {x > y, x == y, x < y};
    endfunction

    // Reference: number of bit pairs examined, MSB first, up to first difference.
    function automatic int ref_k(input logic [c_W-1:0] x, input logic [c_W-1:0] y);
        logic [c_W-1:0] d;
        int k;
        d = x ^ y;
        k = c_W;
        for (int p = 0; p < c_W; p++) begin
            if (d[p]) k = c_W - p;
        end
        return k;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launches one comparison from IDLE and observes it; compares nothing.
    task automatic do_cmp(input logic [c_W-1:0] av, input logic [c_W-1:0] bv,
                          output int edges, output int busy_n,
                          output logic [2:0] flags, output bit timeout);
        bit seen;
        a = av;
        b = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = 8'($urandom);
        b = 8'($urandom);
        edges = 1;
        busy_n = busy ? 1 : 0;
        flags = 3'b000;
        seen = 1'b0;
        while (!seen && edges < 40) begin
            tick();
            edges++;
            if (busy) busy_n++;
            if (done) begin
                seen = 1'b1;
                flags = {gt, eq, lt};
            end
        end
        timeout = !seen;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        a = 8'($urandom);
        b = 8'($urandom);
        tick();
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", done); end
        n_checks++;
        if ({gt, eq, lt} !== 3'b000) begin n_fail++; $display("FAIL reset_flags: got %b expected 000", {gt, eq, lt}); end
        start = 1'b0;
        rst = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_equal();
        int e, bn;
        logic [2:0] f;
        bit to;
        do_cmp(8'hA5, 8'hA5, e, bn, f, to);
        n_checks++;
        if (to) begin n_fail++; $display("FAIL eq_timeout: no done within bound"); end
        n_checks++;
        if (e !== 9) begin n_fail++; $display("FAIL eq_latency: got %0d edges expected 9", e); end
        n_checks++;
        if (bn !== 9) begin n_fail++; $display("FAIL eq_busy_cycles: got %0d expected 9", bn); end
        n_checks++;
        if (f !== 3'b010) begin n_fail++; $display("FAIL eq_flags: got %b expected 010", f); end
        tick();
        n_checks++;
        if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL eq_done_pulse: busy,done got %b expected 00", {busy, done}); end
    endtask

    task automatic test_gt_msb();
        int e, bn;
        logic [2:0] f;
        bit to;
        do_cmp(8'h80, 8'h7F, e, bn, f, to);
        n_checks++;
        if (to || e !== 2) begin n_fail++; $display("FAIL gt_latency: got %0d edges (timeout %0b) expected 2", e, to); end
        n_checks++;
        if (f !== 3'b100) begin n_fail++; $display("FAIL gt_flags: got %b expected 100", f); end
        tick();
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL gt_done_pulse: got %b expected 0", done); end
    endtask

    task automatic test_lt_hold();
        int e, bn;
        logic [2:0] f;
        bit to;
        do_cmp(8'h12, 8'h13, e, bn, f, to);
        n_checks++;
        if (to || e !== 9) begin n_fail++; $display("FAIL lt_latency: got %0d edges (timeout %0b) expected 9", e, to); end
        n_checks++;
        if (f !== 3'b001) begin n_fail++; $display("FAIL lt_flags: got %b expected 001", f); end
        repeat (5) tick();
        n_checks++;
        if ({gt, eq, lt, done} !== 4'b0010) begin n_fail++; $display("FAIL lt_hold: gt,eq,lt,done got %b expected 0010", {gt, eq, lt, done}); end
        a = 8'h55;
        b = 8'hAA;
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++;
        if ({gt, eq, lt, busy} !== 4'b0001) begin n_fail++; $display("FAIL lt_clear_on_start: gt,eq,lt,busy got %b expected 0001", {gt, eq, lt, busy}); end
        tick();
        tick();
    endtask

    task automatic test_start_ignored();
        int n_done;
        a = 8'h00;
        b = 8'hFF;
        start = 1'b1;
        tick();
        a = 8'hFF;
        b = 8'h00;
        tick();
        start = 1'b0;
        n_checks++;
        if ({done, gt, eq, lt} !== 4'b1001) begin n_fail++; $display("FAIL ign_first: done,gt,eq,lt got %b expected 1001", {done, gt, eq, lt}); end
        n_done = 0;
        repeat (12) begin
            tick();
            if (done) n_done++;
        end
        n_checks++;
        if (n_done !== 0) begin n_fail++; $display("FAIL ign_extra_done: got %0d extra done pulses expected 0", n_done); end
        n_checks++;
        if ({busy, gt, eq, lt} !== 4'b0001) begin n_fail++; $display("FAIL ign_final: busy,gt,eq,lt got %b expected 0001", {busy, gt, eq, lt}); end
    endtask

    task automatic test_reset_abort();
        int n_done, e, bn;
        logic [2:0] f;
        bit to;
        n_done = 0;
        a = 8'h0F;
        b = 8'h0E;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) begin
            tick();
            if (done) n_done++;
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (n_done !== 0) begin n_fail++; $display("FAIL abort_early_done: got %0d expected 0", n_done); end
        n_checks++;
        if ({busy, done, gt, eq, lt} !== 5'b00000) begin n_fail++; $display("FAIL abort_outputs: got %b expected 00000", {busy, done, gt, eq, lt}); end
        rst = 1'b0;
        do_cmp(8'h01, 8'h01, e, bn, f, to);
        n_checks++;
        if (to || e !== 9 || f !== 3'b010) begin n_fail++; $display("FAIL abort_restart: edges %0d flags %b timeout %0b expected 9 010 0", e, f, to); end
        tick();
    endtask

    task automatic test_random();
        int e, bn;
        logic [2:0] f;
        bit to;
        logic [c_W-1:0] x, y;
        for (int i = 0; i < 60; i++) begin
            x = 8'($urandom);
            case (i % 3)
                0: y = x;
                1: y = x ^ (8'h01 << $urandom_range(0, 7));
                default: y = 8'($urandom);
            endcase
            do_cmp(x, y, e, bn, f, to);
            n_checks++;
            if (to || e !== ref_k(x, y) + 1 || f !== ref_flags(x, y)) begin
                n_fail++;
                $display("FAIL rand_%0d a=%h b=%h: edges %0d flags %b timeout %0b expected %0d %b", i, x, y, e, f, to, ref_k(x, y) + 1, ref_flags(x, y));
            end
            tick();
        end
    endtask

    task automatic test_back_to_back();
        logic [c_W-1:0] q_a[$];
        logic [c_W-1:0] q_b[$];
        logic [c_W-1:0] cur_a, cur_b;
        int e;
        bit seen;
        for (int i = 0; i < 1001; i++) begin
            q_a.push_back(8'($urandom));
            q_b.push_back((i % 4 == 0) ? q_a[i] : 8'($urandom));
        end
        a = q_a.pop_front();
        b = q_b.pop_front();
        cur_a = a;
        cur_b = b;
        start = 1'b1;
        tick();
        for (int i = 0; i < 1000; i++) begin
            a = q_a.pop_front();
            b = q_b.pop_front();
            e = 1;
            seen = 1'b0;
            while (!seen && e < 40) begin
                tick();
                e++;
                if (done) seen = 1'b1;
            end
            n_checks++;
            if (!seen || e !== ref_k(cur_a, cur_b) + 1 || {gt, eq, lt} !== ref_flags(cur_a, cur_b)) begin
                n_fail++;
                $display("FAIL b2b_%0d a=%h b=%h: edges %0d flags %b seen %0b expected %0d %b", i, cur_a, cur_b, e, {gt, eq, lt}, seen, ref_k(cur_a, cur_b) + 1, ref_flags(cur_a, cur_b));
            end
            tick();
            n_checks++;
            if ({busy, done} !== 2'b00) begin n_fail++; $display("FAIL b2b_idle_%0d: busy,done got %b expected 00", i, {busy, done}); end
            tick();
            n_checks++;
            if ({busy, gt, eq, lt} !== 4'b1000) begin n_fail++; $display("FAIL b2b_restart_%0d: busy,gt,eq,lt got %b expected 1000", i, {busy, gt, eq, lt}); end
            cur_a = a;
            cur_b = b;
        end
        start = 1'b0;
        repeat (12) tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        test_reset();
        test_equal();
        test_gt_msb();
        test_lt_hold();
        test_start_ignored();
        test_reset_abort();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
